// File: rtl/sha_mask_pkg.sv
// Shared definitions for the masked SHA-512 front end: word sizes, FSM states and
// the share-interleave helper that both the masker and unmasker use.
package sha_mask_pkg;

  localparam int unsigned WORD        = 64;
  localparam int unsigned BLOCK_WORDS = 16;
  // Upper bound on share count supported by the interleave helper.
  localparam int unsigned MAX_SHARES  = 8;
  localparam int unsigned BUS_IDX_W   = $clog2(MAX_SHARES * WORD);

  typedef enum logic [1:0] {IDLE, RAND, OUT} state_e;

  // Bit i of share j lands at bus[i*n + j]; bits above WORD*n are left zero.
  function automatic logic [MAX_SHARES*WORD-1:0] interleave_shares(
    input logic [MAX_SHARES-1:0][WORD-1:0] shares,
    input int unsigned                     n
  );
    logic [MAX_SHARES*WORD-1:0] bus;
    logic [BUS_IDX_W-1:0]       idx;
    bus = '0;
    for (int unsigned i = 0; i < WORD; i++) begin
      for (int unsigned j = 0; j < MAX_SHARES; j++) begin
        if (j < n) begin
          idx      = BUS_IDX_W'(i * n + j);
          bus[idx] = shares[j][i];
        end
      end
    end
    return bus;
  endfunction

endpackage

// File: rtl/sha_word_masker.sv
// Boolean-masking encoder: splits one 64-bit message word into d interleaved shares
// using d-1 fresh PRNG words, and flags the last word of each 1024-bit block.
module sha_word_masker #(
  parameter int unsigned d           = 2,
  parameter int unsigned BLOCK_WORDS = sha_mask_pkg::BLOCK_WORDS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [sha_mask_pkg::WORD-1:0]  in_data,
  input  logic                           rnd_valid,
  output logic                           rnd_ready,
  input  logic [sha_mask_pkg::WORD-1:0]  rnd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [sha_mask_pkg::WORD*d-1:0] out_data,
  output logic                           out_last
);
  import sha_mask_pkg::*;

  localparam int unsigned CntW = $clog2(d);
  localparam int unsigned IdxW = $clog2(BLOCK_WORDS);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         rcnt_q, rcnt_d;
  logic [IdxW-1:0]         word_idx_q, word_idx_d;
  logic [d-1:0][WORD-1:0]  shares_q, shares_d;
  int unsigned             rnd_slot;

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    word_idx_d = word_idx_q;
    shares_d   = shares_q;
    rnd_slot   = 32'(rcnt_q) + 32'd1;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shares_d[0] = in_data;
          rcnt_d      = '0;
          state_d     = RAND;
        end
      end
      RAND: begin
        if (rnd_valid) begin
          // Share 0 accumulates x ^ r_1 ^ ... while r_k is stored verbatim as share k.
          shares_d[0] = shares_q[0] ^ rnd_data;
          for (int unsigned j = 1; j < d; j++) begin
            if (j == rnd_slot) shares_d[j] = rnd_data;
          end
          rcnt_d = rcnt_q + CntW'(1);
          if (rcnt_q == CntW'(d - 2)) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          word_idx_d = (word_idx_q == IdxW'(BLOCK_WORDS - 1)) ? '0 : word_idx_q + IdxW'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      word_idx_q <= '0;
      shares_q   <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      word_idx_q <= word_idx_d;
      shares_q   <= shares_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign rnd_ready = (state_q == RAND);
  assign out_valid = (state_q == OUT);
  assign out_last  = out_valid && (word_idx_q == IdxW'(BLOCK_WORDS - 1));

  logic [MAX_SHARES-1:0][WORD-1:0] shares_pad;
  logic [MAX_SHARES*WORD-1:0]      bus;

  always_comb begin
    shares_pad        = '0;
    shares_pad[d-1:0] = shares_q;
  end

  assign bus      = interleave_shares(shares_pad, d);
  assign out_data = bus[WORD*d-1:0];

  if (d < MAX_SHARES) begin : g_unused_bus
    logic unused_bus;
    assign unused_bus = ^bus[MAX_SHARES*WORD-1:WORD*d];
  end

endmodule
